// File: rtl/uart_prog_loader.sv
// UART programming-interface initiator: 8N1 receiver with 16x oversampling feeding a
// frame parser that turns {header, count, little-endian words} into one-cycle memory writes.
module uart_prog_loader #(
  parameter int OVS_DIV = 5,
  parameter int ADDR_W  = 14,
  parameter int TIMEOUT = 2000000
) (
  input  logic              upg_clk_i,
  input  logic              upg_rst_i,
  input  logic              upg_rx_i,
  output logic              upg_wen_o,
  output logic [ADDR_W:0]   upg_adr_o,
  output logic [31:0]       upg_dat_o,
  output logic              upg_done_o,
  output logic              upg_busy_o,
  output logic              upg_err_o
);
  localparam int TW  = (OVS_DIV > 1) ? $clog2(OVS_DIV) : 1;
  localparam int TOW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_st_e;
  typedef enum logic [1:0] {F_HDR, F_CNT0, F_CNT1, F_WORD} fr_st_e;

  logic          rx_s1_q, rx_s2_q, rx_prev_q;
  logic [TW-1:0] div_q;
  logic          tick;
  rx_st_e        rx_st_q, rx_st_d;
  logic [3:0]    os_q, os_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          bvld_q, bvld_d, berr_q, berr_d;

  fr_st_e        fr_q, fr_d;
  logic          tgt_q, tgt_d;
  logic [7:0]    cntl_q, cntl_d;
  logic [15:0]   n_q, n_d;
  logic [ADDR_W:0] idx_q, idx_d;
  logic [1:0]    bc_q, bc_d;
  logic [23:0]   word_q, word_d;
  logic [TOW-1:0] to_q, to_d;
  logic          wen_q, wen_d, done_q, done_d, busy_q, busy_d, err_q, err_d;
  logic [ADDR_W:0] adr_q, adr_d;
  logic [31:0]   dat_q, dat_d;
  logic          timeout;

  assign tick = (div_q == TW'(OVS_DIV - 1));

  // Receiver: start is qualified at mid-bit, data and stop sampled every 16 ticks after that
  always_comb begin
    rx_st_d = rx_st_q;
    os_d    = os_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    bvld_d  = 1'b0;
    berr_d  = 1'b0;
    case (rx_st_q)
      R_IDLE: if (rx_prev_q && !rx_s2_q) begin
        rx_st_d = R_START;
        os_d    = 4'd0;
      end
      R_START: if (tick) begin
        os_d = os_q + 4'd1;
        if (os_q == 4'd7) begin
          os_d    = 4'd0;
          bit_d   = 3'd0;
          rx_st_d = rx_s2_q ? R_IDLE : R_DATA;
        end
      end
      R_DATA: if (tick) begin
        os_d = os_q + 4'd1;
        if (os_q == 4'd15) begin
          sh_d  = {rx_s2_q, sh_q[7:1]};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) rx_st_d = R_STOP;
        end
      end
      R_STOP: if (tick) begin
        os_d = os_q + 4'd1;
        if (os_q == 4'd15) begin
          bvld_d  = rx_s2_q;
          berr_d  = !rx_s2_q;
          rx_st_d = R_IDLE;
        end
      end
      default: rx_st_d = R_IDLE;
    endcase
  end

  assign timeout = (fr_q != F_HDR) && !bvld_q && (to_q == TOW'(TIMEOUT - 1));

  // Frame parser and write issue
  always_comb begin
    fr_d   = fr_q;
    tgt_d  = tgt_q;
    cntl_d = cntl_q;
    n_d    = n_q;
    idx_d  = idx_q;
    bc_d   = bc_q;
    word_d = word_q;
    wen_d  = 1'b0;
    adr_d  = adr_q;
    dat_d  = dat_q;
    done_d = done_q;
    busy_d = busy_q;
    err_d  = err_q;
    to_d   = (fr_q == F_HDR || bvld_q) ? '0 : to_q + TOW'(1);
    if (berr_q) begin
      err_d  = 1'b1;
      busy_d = 1'b0;
      fr_d   = F_HDR;
    end else if (bvld_q) begin
      case (fr_q)
        F_HDR: if (sh_q == 8'hA5 || sh_q == 8'h5A) begin
          err_d  = 1'b0;
          done_d = 1'b0;
          busy_d = 1'b1;
          tgt_d  = (sh_q == 8'h5A);
          idx_d  = '0;
          fr_d   = F_CNT0;
        end
        F_CNT0: begin
          cntl_d = sh_q;
          fr_d   = F_CNT1;
        end
        F_CNT1: begin
          n_d  = {sh_q, cntl_q};
          bc_d = 2'd0;
          fr_d = F_WORD;
          if ({sh_q, cntl_q} == 16'd0) begin
            done_d = 1'b1;
            busy_d = 1'b0;
            fr_d   = F_HDR;
          end else if (32'({sh_q, cntl_q}) > (32'd1 << ADDR_W)) begin
            err_d  = 1'b1;
            busy_d = 1'b0;
            fr_d   = F_HDR;
          end
        end
        F_WORD: begin
          word_d = {sh_q, word_q[23:8]};
          bc_d   = bc_q + 2'd1;
          if (bc_q == 2'd3) begin
            wen_d = 1'b1;
            adr_d = {tgt_q, idx_q[ADDR_W-1:0]};
            dat_d = {sh_q, word_q};
            idx_d = idx_q + 1'b1;
            if (32'(idx_q) + 32'd1 == 32'(n_q)) begin
              done_d = 1'b1;
              busy_d = 1'b0;
              fr_d   = F_HDR;
            end
          end
        end
        default: fr_d = F_HDR;
      endcase
    end else if (timeout) begin
      err_d  = 1'b1;
      busy_d = 1'b0;
      fr_d   = F_HDR;
    end
  end

  always_ff @(posedge upg_clk_i or posedge upg_rst_i) begin
    if (upg_rst_i) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
      div_q     <= '0;
      rx_st_q   <= R_IDLE;
      os_q      <= 4'd0;
      bit_q     <= 3'd0;
      sh_q      <= 8'd0;
      bvld_q    <= 1'b0;
      berr_q    <= 1'b0;
      fr_q      <= F_HDR;
      tgt_q     <= 1'b0;
      cntl_q    <= 8'd0;
      n_q       <= 16'd0;
      idx_q     <= '0;
      bc_q      <= 2'd0;
      word_q    <= 24'd0;
      to_q      <= '0;
      wen_q     <= 1'b0;
      adr_q     <= '0;
      dat_q     <= 32'd0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      rx_s1_q   <= upg_rx_i;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      div_q     <= tick ? '0 : div_q + TW'(1);
      rx_st_q   <= rx_st_d;
      os_q      <= os_d;
      bit_q     <= bit_d;
      sh_q      <= sh_d;
      bvld_q    <= bvld_d;
      berr_q    <= berr_d;
      fr_q      <= fr_d;
      tgt_q     <= tgt_d;
      cntl_q    <= cntl_d;
      n_q       <= n_d;
      idx_q     <= idx_d;
      bc_q      <= bc_d;
      word_q    <= word_d;
      to_q      <= to_d;
      wen_q     <= wen_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end

  assign upg_wen_o  = wen_q;
  assign upg_adr_o  = adr_q;
  assign upg_dat_o  = dat_q;
  assign upg_done_o = done_q;
  assign upg_busy_o = busy_q;
  assign upg_err_o  = err_q;
endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed bench for uart_prog_loader: drives 8N1 frames at 80 clocks/bit and checks
// the write strobes and status flags against hand-computed values.
module tb_uart_prog_loader;
  localparam int OVS_DIV = 5;
  localparam int ADDR_W  = 14;
  localparam int TIMEOUT = 1000;
  localparam int BIT     = OVS_DIV * 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            rx  = 1'b1;
  logic            wen;
  logic [ADDR_W:0] adr;
  logic [31:0]     dat;
  logic            done, busy, err;

  int n_vec = 0;
  int n_err = 0;

  logic [ADDR_W:0] wadr [0:15];
  logic [31:0]     wdat [0:15];
  int              wcnt = 0;
  int              base;

  uart_prog_loader #(.OVS_DIV(OVS_DIV), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .upg_clk_i (clk),
    .upg_rst_i (rst),
    .upg_rx_i  (rx),
    .upg_wen_o (wen),
    .upg_adr_o (adr),
    .upg_dat_o (dat),
    .upg_done_o(done),
    .upg_busy_o(busy),
    .upg_err_o (err)
  );

  always #50 clk = ~clk;

  always @(negedge clk) begin
    if (wen && wcnt < 16) begin
      wadr[wcnt] <= adr;
      wdat[wcnt] <= dat;
    end
    if (wen) wcnt <= wcnt + 1;
  end

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
    rx = 1'b0;
    cyc(BIT);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      cyc(BIT);
    end
    rx = stop;
    cyc(BIT);
    rx = 1'b1;
  endtask

  initial begin
    cyc(5);
    chk_eq("rst_wen",  32'(wen),  32'd0);
    chk_eq("rst_adr",  32'(adr),  32'd0);
    chk_eq("rst_dat",  dat,       32'd0);
    chk_eq("rst_done", 32'(done), 32'd0);
    chk_eq("rst_busy", 32'(busy), 32'd0);
    chk_eq("rst_err",  32'(err),  32'd0);
    rst = 1'b0;
    cyc(BIT * 2);

    // Two-word instruction frame
    base = wcnt;
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
    cyc(4);
    chk_eq("t1_busy_hdr", 32'(busy), 32'd1);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    cyc(4);
    chk_eq("t1_wcnt_mid", 32'(wcnt - base), 32'd1);
    chk_eq("t1_done_mid", 32'(done), 32'd0);
    chk_eq("t1_busy_mid", 32'(busy), 32'd1);
    send_byte(8'h55); send_byte(8'h66); send_byte(8'h77); send_byte(8'h88);
    cyc(20);
    chk_eq("t1_wcnt", 32'(wcnt - base), 32'd2);
    chk_eq("t1_adr0", 32'(wadr[base]), 32'h0000);
    chk_eq("t1_dat0", wdat[base], 32'h44332211);
    chk_eq("t1_adr1", 32'(wadr[base+1]), 32'h0001);
    chk_eq("t1_dat1", wdat[base+1], 32'h88776655);
    chk_eq("t1_hold_dat", dat, 32'h88776655);
    chk_eq("t1_done", 32'(done), 32'd1);
    chk_eq("t1_busy", 32'(busy), 32'd0);
    chk_eq("t1_err",  32'(err),  32'd0);

    // Single word to data memory
    base = wcnt;
    send_byte(8'h5A); send_byte(8'h01); send_byte(8'h00);
    cyc(4);
    chk_eq("t2_done_clr", 32'(done), 32'd0);
    send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
    cyc(20);
    chk_eq("t2_wcnt", 32'(wcnt - base), 32'd1);
    chk_eq("t2_adr",  32'(wadr[base]), 32'h4000);
    chk_eq("t2_dat",  wdat[base], 32'hEFBEADDE);
    chk_eq("t2_done", 32'(done), 32'd1);

    // Empty frame
    base = wcnt;
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
    cyc(20);
    chk_eq("t3_wcnt", 32'(wcnt - base), 32'd0);
    chk_eq("t3_done", 32'(done), 32'd1);
    chk_eq("t3_busy", 32'(busy), 32'd0);

    // Framing error mid-frame, then recovery
    base = wcnt;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h11, 1'b0);
    cyc(BIT);
    chk_eq("t4_err",  32'(err),  32'd1);
    chk_eq("t4_busy", 32'(busy), 32'd0);
    chk_eq("t4_wcnt", 32'(wcnt - base), 32'd0);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
    cyc(4);
    chk_eq("t4_err_clr", 32'(err), 32'd0);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    cyc(20);
    chk_eq("t4_wcnt2", 32'(wcnt - base), 32'd1);
    chk_eq("t4_dat",   wdat[base], 32'h04030201);
    chk_eq("t4_adr",   32'(wadr[base]), 32'h0000);
    chk_eq("t4_done",  32'(done), 32'd1);

    // Inter-byte timeout
    base = wcnt;
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h00);
    send_byte(8'h10); send_byte(8'h20); send_byte(8'h30); send_byte(8'h40);
    send_byte(8'h50);
    cyc(900);
    chk_eq("t5_err_early", 32'(err),  32'd0);
    chk_eq("t5_busy_early", 32'(busy), 32'd1);
    cyc(200);
    chk_eq("t5_wcnt", 32'(wcnt - base), 32'd1);
    chk_eq("t5_dat",  wdat[base], 32'h40302010);
    chk_eq("t5_err",  32'(err),  32'd1);
    chk_eq("t5_busy", 32'(busy), 32'd0);
    chk_eq("t5_done", 32'(done), 32'd0);

    // Reset in the middle of a word
    base = wcnt;
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
    send_byte(8'hAA); send_byte(8'hBB);
    rst = 1'b1;
    #1;
    chk_eq("t6_rst_adr",  32'(adr),  32'd0);
    chk_eq("t6_rst_dat",  dat,       32'd0);
    chk_eq("t6_rst_busy", 32'(busy), 32'd0);
    chk_eq("t6_rst_err",  32'(err),  32'd0);
    cyc(3);
    rst = 1'b0;
    cyc(BIT);
    send_byte(8'hFF);
    cyc(BIT);
    chk_eq("t6_wcnt", 32'(wcnt - base), 32'd0);
    chk_eq("t6_err",  32'(err),  32'd0);
    chk_eq("t6_busy", 32'(busy), 32'd0);
    chk_eq("t6_done", 32'(done), 32'd0);
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
    cyc(20);
    chk_eq("t6_hdr_done", 32'(done), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
